cpu_step_controller: RTL and testbench

//  Sequences the pipelined MIPS core for board-level debug: converts debounced step/run button

---
 rtl/cpu_dbg_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 32 +++
 rtl/cpu_step_controller.sv | 133 +++++++++++++
 tb/tb_cpu_step_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the board-level CPU debug step controller.
package cpu_dbg_pkg;

  localparam int unsigned DBG_CYCLES_W = 32;
  localparam int unsigned STEP_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    RUN,
    BREAK
  } dbg_state_t;

  // A step request of 0 cycles still executes one cycle.
  function automatic logic [STEP_CNT_W-1:0] step_load(input logic [STEP_CNT_W-1:0] n);
    return (n == '0) ? STEP_CNT_W'(1) : n;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Run/step tick generator: every cycle when fast, else once per RUN_DIV cycles.
module tick_prescaler #(
  parameter int unsigned DIV_W   = 28,
  parameter int unsigned RUN_DIV = 50_000_000
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic fast,
  output logic tick
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(RUN_DIV - 1);

  logic [DIV_W-1:0] div;

  assign tick = fast | (div == '0);

  // load forces the first tick into the first cycle of the newly entered state
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      div <= '0;
    end else if (load) begin
      div <= '0;
    end else if (tick) begin
      div <= RELOAD;
    end else begin
      div <= div - DIV_W'(1);
    end
  end

endmodule

// File: rtl/cpu_step_controller.sv
// Converts debounced step/run button edges into processor clock enables,
// with N-cycle stepping, free/divided run, PC breakpoint and core-halt stop.
module cpu_step_controller
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned RUN_DIV = 50_000_000,
  parameter int unsigned DIV_W   = 28,
  parameter int unsigned PC_W    = 32
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    btn_step,
  input  logic                    btn_run,
  input  logic [STEP_CNT_W-1:0]   step_count,
  input  logic                    fast,
  input  logic                    bp_en,
  input  logic [PC_W-1:0]         bp_addr,
  input  logic [PC_W-1:0]         pc,
  input  logic                    cpu_halt,
  output logic                    cpu_en,
  output logic                    running,
  output logic                    at_bp,
  output logic [DBG_CYCLES_W-1:0] cycles
);

  dbg_state_t            state, state_nx;
  logic                  btn_step_q, btn_run_q;
  logic [STEP_CNT_W-1:0] remain, remain_nx;
  logic                  armed, armed_nx;
  logic                  step_rise, run_rise, bp_hit;
  logic                  tick, load;

  assign step_rise = btn_step & ~btn_step_q;
  assign run_rise  = btn_run & ~btn_run_q;
  assign bp_hit    = bp_en & armed & (pc == bp_addr);

  assign running = (state == RUN);
  assign at_bp   = (state == BREAK);

  assign load = (state_nx != state) && ((state_nx == STEP) || (state_nx == RUN));

  tick_prescaler #(
    .DIV_W  (DIV_W),
    .RUN_DIV(RUN_DIV)
  ) u_tick (
    .clk  (clk),
    .clear(clear),
    .load (load),
    .fast (fast),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      btn_step_q <= 1'b0;
      btn_run_q  <= 1'b0;
      remain     <= '0;
      armed      <= 1'b0;
      cycles     <= '0;
    end else begin
      state      <= state_nx;
      btn_step_q <= btn_step;
      btn_run_q  <= btn_run;
      remain     <= remain_nx;
      armed      <= armed_nx;
      if (cpu_en) begin
        cycles <= cycles + DBG_CYCLES_W'(1);
      end
    end
  end

  // Next state, enable and step/arm bookkeeping
  always_comb begin
    state_nx  = state;
    remain_nx = remain;
    armed_nx  = 1'b0;
    cpu_en    = 1'b0;

    unique case (state)
      IDLE: begin
        if (cpu_halt) begin
          state_nx = IDLE;
        end else if (run_rise) begin
          state_nx = RUN;
        end else if (step_rise) begin
          state_nx = STEP;
        end
      end
      STEP: begin
        cpu_en = tick & ~cpu_halt;
        if (cpu_en) begin
          remain_nx = remain - STEP_CNT_W'(1);
        end
        if (cpu_halt) begin
          state_nx = IDLE;
        end else if (cpu_en && (remain <= STEP_CNT_W'(1))) begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        cpu_en = tick & ~cpu_halt & ~bp_hit & ~run_rise;
        if (cpu_halt) begin
          state_nx = IDLE;
        end else if (run_rise) begin
          state_nx = IDLE;
        end else if (tick && bp_hit) begin
          state_nx = BREAK;
        end
      end
      BREAK: begin
        if (cpu_halt) begin
          state_nx = IDLE;
        end else if (run_rise) begin
          state_nx = RUN;
        end else if (step_rise) begin
          state_nx = STEP;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load && (state_nx == STEP)) begin
      remain_nx = step_load(step_count);
    end

    // Disarmed on RUN entry so a resume from BREAK executes the breakpoint PC
    if ((state_nx == RUN) && (state == RUN)) begin
      armed_nx = armed | cpu_en;
    end
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller: stepping, divided run, breakpoint, halt and clear.
module tb_cpu_step_controller;

  logic        clk;
  logic        clear;
  logic        btn_step;
  logic        btn_run;
  logic [7:0]  step_count;
  logic        fast;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_halt;
  logic        cpu_en;
  logic        running;
  logic        at_bp;
  logic [31:0] cycles;
  logic        pc_rst;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_step_controller #(
    .RUN_DIV(4),
    .DIV_W  (8),
    .PC_W   (32)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .btn_step  (btn_step),
    .btn_run   (btn_run),
    .step_count(step_count),
    .fast      (fast),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_halt  (cpu_halt),
    .cpu_en    (cpu_en),
    .running   (running),
    .at_bp     (at_bp),
    .cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: fetch PC advances by 4 on each enabled cycle
  always @(posedge clk) begin
    if (pc_rst) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic [31:0] exp_pc [1:10];
  logic        exp_en4 [1:10];

  initial begin
    clear = 1'b1; btn_step = 1'b1; btn_run = 1'b1; step_count = 8'd3;
    fast = 1'b1; bp_en = 1'b0; bp_addr = 32'h10; cpu_halt = 1'b0; pc_rst = 1'b1;

    // 1: reset with buttons held
    repeat (3) next_cycle();
    settle();
    chk("rst_en", 32'(cpu_en), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_at_bp", 32'(at_bp), 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    btn_step = 1'b0; btn_run = 1'b0;
    next_cycle();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); settle();
      chk("idle_en", 32'(cpu_en), 32'd0);
    end

    // 2: three-cycle step, step_count changed mid-step is ignored
    next_cycle(); btn_step = 1'b1; step_count = 8'd3; settle();
    chk("t2_rise_en", 32'(cpu_en), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      next_cycle(); btn_step = 1'b0;
      if (i == 1) step_count = 8'd7;
      settle();
      chk("t2_step3_en", 32'(cpu_en), 32'(i <= 3));
    end
    chk("t2_cycles3", cycles, 32'd3);
    next_cycle(); step_count = 8'd0; btn_step = 1'b1; settle();
    chk("t2_rise0_en", 32'(cpu_en), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); btn_step = 1'b0; settle();
      chk("t2_step0_en", 32'(cpu_en), 32'(i == 1));
    end
    chk("t2_cycles4", cycles, 32'd4);

    // 3: divided run, tick every 4th cycle, second run pulse stops
    next_cycle(); fast = 1'b0; btn_run = 1'b1; settle();
    chk("t3_rise_en", 32'(cpu_en), 32'd0);
    chk("t3_rise_running", 32'(running), 32'd0);
    for (int i = 1; i <= 13; i++) begin
      next_cycle(); btn_run = (i == 13); settle();
      chk("t3_run_en", 32'(cpu_en), 32'((i % 4 == 1) && (i != 13)));
      chk("t3_running", 32'(running), 32'd1);
    end
    next_cycle(); btn_run = 1'b0; settle();
    chk("t3_stop_running", 32'(running), 32'd0);
    chk("t3_stop_en", 32'(cpu_en), 32'd0);
    chk("t3_cycles", cycles, 32'd7);

    // 4: breakpoint at 0x10 and resume past it
    exp_pc[1] = 32'h0;  exp_pc[2] = 32'h4;  exp_pc[3] = 32'h8;  exp_pc[4] = 32'hC;
    exp_pc[5] = 32'h10; exp_pc[6] = 32'h10; exp_pc[7] = 32'h10; exp_pc[8] = 32'h10;
    exp_pc[9] = 32'h14; exp_pc[10] = 32'h18;
    exp_en4[1] = 1; exp_en4[2] = 1; exp_en4[3] = 1; exp_en4[4] = 1; exp_en4[5] = 0;
    exp_en4[6] = 0; exp_en4[7] = 0; exp_en4[8] = 1; exp_en4[9] = 1; exp_en4[10] = 0;
    next_cycle(); fast = 1'b1; bp_en = 1'b1; pc_rst = 1'b1;
    next_cycle(); pc_rst = 1'b0; btn_run = 1'b1; settle();
    chk("t4_rise_en", 32'(cpu_en), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      next_cycle(); btn_run = (i == 7) || (i == 10); settle();
      chk("t4_pc", pc, exp_pc[i]);
      chk("t4_en", 32'(cpu_en), 32'(exp_en4[i]));
      chk("t4_at_bp", 32'(at_bp), 32'((i == 6) || (i == 7)));
    end
    next_cycle(); btn_run = 1'b0; bp_en = 1'b0; settle();
    chk("t4_stop_running", 32'(running), 32'd0);
    chk("t4_cycles", cycles, 32'd13);

    // 5a: halt during RUN, buttons ignored while halted
    next_cycle(); btn_run = 1'b1; settle();
    for (int i = 1; i <= 7; i++) begin
      next_cycle();
      cpu_halt = (i >= 3); btn_step = (i == 4); btn_run = (i == 6);
      settle();
      chk("t5_run_en", 32'(cpu_en), 32'(i <= 2));
      chk("t5_running", 32'(running), 32'(i <= 3));
    end
    next_cycle(); cpu_halt = 1'b0; btn_step = 1'b0; btn_run = 1'b0; settle();
    chk("t5_after_halt_en", 32'(cpu_en), 32'd0);
    chk("t5_cycles_a", cycles, 32'd15);

    // 5b: halt mid-step with 5 cycles remaining
    next_cycle(); step_count = 8'd8; btn_step = 1'b1; settle();
    for (int i = 1; i <= 7; i++) begin
      next_cycle(); btn_step = 1'b0; cpu_halt = (i == 4); settle();
      chk("t5_step_en", 32'(cpu_en), 32'(i <= 3));
    end
    chk("t5_cycles_b", cycles, 32'd18);

    // 6a: asynchronous clear mid-RUN
    next_cycle(); btn_run = 1'b1; settle();
    next_cycle(); btn_run = 1'b0; settle();
    chk("t6_run_en", 32'(cpu_en), 32'd1);
    next_cycle(); settle();
    chk("t6_cycles_pre", cycles, 32'd19);
    clear = 1'b1; #1;
    chk("t6_clr_run_en", 32'(cpu_en), 32'd0);
    chk("t6_clr_running", 32'(running), 32'd0);
    chk("t6_clr_cycles", cycles, 32'd0);
    next_cycle(); clear = 1'b0; settle();
    chk("t6_post_running", 32'(running), 32'd0);

    // 6b: asynchronous clear mid-STEP leaves no pending step
    next_cycle(); step_count = 8'd5; btn_step = 1'b1; settle();
    next_cycle(); btn_step = 1'b0; settle();
    chk("t6_step_en", 32'(cpu_en), 32'd1);
    next_cycle(); settle();
    clear = 1'b1; #1;
    chk("t6_clr_step_en", 32'(cpu_en), 32'd0);
    chk("t6_clr_step_cycles", cycles, 32'd0);
    next_cycle(); clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); settle();
      chk("t6_no_pending", 32'(cpu_en), 32'd0);
    end

    // 6c: simultaneous step and run rise selects RUN
    next_cycle(); step_count = 8'd1; btn_step = 1'b1; btn_run = 1'b1; settle();
    chk("t6_both_rise_en", 32'(cpu_en), 32'd0);
    next_cycle(); btn_step = 1'b0; btn_run = 1'b0; settle();
    chk("t6_both_running", 32'(running), 32'd1);
    chk("t6_both_en1", 32'(cpu_en), 32'd1);
    next_cycle(); settle();
    chk("t6_both_en2", 32'(cpu_en), 32'd1);
    next_cycle(); btn_run = 1'b1; settle();
    chk("t6_stop_en", 32'(cpu_en), 32'd0);
    next_cycle(); btn_run = 1'b0; settle();
    chk("t6_stop_running", 32'(running), 32'd0);
    chk("t6_cycles", cycles, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
